// File: rtl/glb_strm_st_dma_pkg.sv
// Shared types and constants for the GLB store-direction stream DMA.
package glb_strm_st_dma_pkg;

    localparam int BANK_DW     = 64;
    localparam int CGRA_DW     = 16;
    localparam int GLB_AW      = 22;
    localparam int NUM_WORDS_W = 16;
    localparam int ST_Q_DEPTH  = 4;

    localparam int CGRA_WORDS_PER_BANK_WORD = BANK_DW / CGRA_DW;
    localparam int BANK_STRB_W              = BANK_DW / 8;

    localparam logic [1:0] DMA_OFF   = 2'd0;
    localparam logic [1:0] NORMAL    = 2'd1;
    localparam logic [1:0] REPEAT    = 2'd2;
    localparam logic [1:0] AUTO_INCR = 2'd3;

    typedef struct packed {
        logic                   wr_en;
        logic [BANK_STRB_W-1:0] wr_strb;
        logic [GLB_AW-1:0]      wr_addr;
        logic [BANK_DW-1:0]     wr_data;
    } wr_packet_t;

    typedef struct packed {
        logic                   valid;
        logic [GLB_AW-1:0]      start_addr;
        logic [NUM_WORDS_W-1:0] num_words;
    } dma_st_header_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } st_dma_state_t;

endpackage

// File: rtl/glb_strm_st_dma_if.sv
// Fabric-to-GLB stream input and bank write output of the store DMA.
interface glb_strm_st_dma_if;
    import glb_strm_st_dma_pkg::*;

    logic [CGRA_DW-1:0] stream_data_f2g;
    logic               stream_data_valid_f2g;
    wr_packet_t         wr_packet;

    modport master (
        output stream_data_f2g,
        output stream_data_valid_f2g,
        input  wr_packet
    );

    modport slave (
        input  stream_data_f2g,
        input  stream_data_valid_f2g,
        output wr_packet
    );
endinterface

// File: rtl/glb_strm_st_dma_word_packer.sv
// Packs stream words into bank words with byte strobes and emits registered writes.
module glb_st_word_packer
    import glb_strm_st_dma_pkg::*;
#(
    parameter int BANK_DATA_WIDTH = BANK_DW,
    parameter int CGRA_DATA_WIDTH = CGRA_DW,
    parameter int GLB_ADDR_WIDTH  = GLB_AW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       word_valid,
    input  logic                       word_last,
    input  logic [CGRA_DATA_WIDTH-1:0] word,
    input  logic [GLB_ADDR_WIDTH-1:0]  addr,
    output wr_packet_t                 wr_packet
);

    localparam int LANES      = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int STRB_W     = BANK_DATA_WIDTH / 8;
    localparam int BYTE_OFF_W = $clog2(STRB_W);
    localparam int LANE_STRB  = CGRA_DATA_WIDTH / 8;

    logic [BANK_DATA_WIDTH-1:0] pack_q, pack_d;
    logic [STRB_W-1:0]          strb_q, strb_d;
    logic [LANE_W-1:0]          lane;
    logic                       emit;

    assign lane = addr[BYTE_OFF_W-1 -: LANE_W];

    always_comb begin
        pack_d = pack_q;
        strb_d = strb_q;
        pack_d[lane*CGRA_DATA_WIDTH +: CGRA_DATA_WIDTH] = word;
        strb_d[lane*LANE_STRB +: LANE_STRB] = '1;
        emit = word_valid && ((lane == LANE_W'(LANES - 1)) || word_last);
    end

    // Pack data is cleared on emit so a partial bank word never carries stale lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q    <= '0;
            strb_q    <= '0;
            wr_packet <= '0;
        end else if (clear) begin
            pack_q          <= '0;
            strb_q          <= '0;
            wr_packet.wr_en <= 1'b0;
        end else begin
            wr_packet.wr_en <= emit;
            if (emit) begin
                wr_packet.wr_strb <= strb_d;
                wr_packet.wr_addr <= addr & ~GLB_ADDR_WIDTH'(STRB_W - 1);
                wr_packet.wr_data <= pack_d;
                pack_q            <= '0;
                strb_q            <= '0;
            end else if (word_valid) begin
                pack_q <= pack_d;
                strb_q <= strb_d;
            end
        end
    end

endmodule

// File: rtl/glb_strm_st_dma.sv
// GLB store stream DMA: header sequencing FSM and address counter around the word packer.
// Optional GLB_ST_DMA_DROP_CNT_EN adds a saturating counter of dropped stream words.
//
// state  | meaning
// IDLE   | waiting for a start pulse
// LOAD   | latching the current header slot
// STREAM | accepting stream words into the packer
// FLUSH  | header finished, choose next slot / done
module glb_strm_st_dma
    import glb_strm_st_dma_pkg::*;
#(
    parameter int BANK_DATA_WIDTH     = BANK_DW,
    parameter int CGRA_DATA_WIDTH     = CGRA_DW,
    parameter int GLB_ADDR_WIDTH      = GLB_AW,
    parameter int MAX_NUM_WORDS_WIDTH = NUM_WORDS_W,
    parameter int QUEUE_DEPTH         = ST_Q_DEPTH
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [1:0]                          cfg_st_dma_mode,
    input  dma_st_header_t [QUEUE_DEPTH-1:0]    cfg_st_dma_header,
    input  logic                                st_dma_start_pulse,
    glb_strm_st_dma_if.slave                    strm,
    output logic                                st_dma_busy,
`ifdef GLB_ST_DMA_DROP_CNT_EN
    output logic [15:0]                         st_dma_drop_cnt,
`endif
    output logic                                st_dma_done_pulse
);

    localparam int IDX_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    st_dma_state_t                  state_q, state_d;
    logic [IDX_W-1:0]               slot_q, slot_d;
    logic [GLB_ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [MAX_NUM_WORDS_WIDTH-1:0] left_q, left_d;
    logic                           reload_q, reload_d;
    logic                           done_d, word_take, abort, last_word, last_slot;
    dma_st_header_t                 cur_hdr;

    assign cur_hdr     = cfg_st_dma_header[slot_q];
    assign last_word   = (left_q == MAX_NUM_WORDS_WIDTH'(1));
    assign last_slot   = (slot_q == IDX_W'(QUEUE_DEPTH - 1));
    assign st_dma_busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            slot_q            <= '0;
            addr_q            <= '0;
            left_q            <= '0;
            reload_q          <= 1'b0;
            st_dma_done_pulse <= 1'b0;
        end else begin
            state_q           <= state_d;
            slot_q            <= slot_d;
            addr_q            <= addr_d;
            left_q            <= left_d;
            reload_q          <= reload_d;
            st_dma_done_pulse <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        addr_d    = addr_q;
        left_d    = left_q;
        reload_d  = reload_q;
        done_d    = 1'b0;
        word_take = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (st_dma_start_pulse && cfg_st_dma_mode != DMA_OFF) begin
                    state_d  = LOAD;
                    slot_d   = '0;
                    reload_d = 1'b0;
                end
            end
            LOAD: begin
                // AUTO_INCR reloads keep the running address as the new start.
                if (!reload_q) addr_d = cur_hdr.start_addr & ~GLB_ADDR_WIDTH'(1);
                left_d   = cur_hdr.num_words;
                reload_d = 1'b0;
                state_d  = (cur_hdr.valid && cur_hdr.num_words != '0) ? STREAM : FLUSH;
            end
            STREAM: begin
                if (strm.stream_data_valid_f2g) begin
                    word_take = 1'b1;
                    addr_d    = addr_q + GLB_ADDR_WIDTH'(2);
                    left_d    = left_q - MAX_NUM_WORDS_WIDTH'(1);
                    if (last_word) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (cfg_st_dma_mode == AUTO_INCR) begin
                    state_d  = LOAD;
                    reload_d = 1'b1;
                    done_d   = 1'b1;
                end else if (!last_slot && cfg_st_dma_header[slot_q + IDX_W'(1)].valid) begin
                    state_d = LOAD;
                    slot_d  = slot_q + IDX_W'(1);
                end else if (cfg_st_dma_mode == REPEAT) begin
                    state_d = LOAD;
                    slot_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && cfg_st_dma_mode == DMA_OFF) begin
            state_d   = IDLE;
            reload_d  = 1'b0;
            done_d    = 1'b0;
            word_take = 1'b0;
            abort     = 1'b1;
        end
    end

    glb_st_word_packer #(
        .BANK_DATA_WIDTH (BANK_DATA_WIDTH),
        .CGRA_DATA_WIDTH (CGRA_DATA_WIDTH),
        .GLB_ADDR_WIDTH  (GLB_ADDR_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst_n      (reset_n),
        .clear      (abort),
        .word_valid (word_take),
        .word_last  (last_word),
        .word       (strm.stream_data_f2g),
        .addr       (addr_q),
        .wr_packet  (strm.wr_packet)
    );

`ifdef GLB_ST_DMA_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_dma_drop_cnt <= '0;
        end else if (st_dma_start_pulse) begin
            st_dma_drop_cnt <= '0;
        end else if (strm.stream_data_valid_f2g && state_q != STREAM
                     && st_dma_drop_cnt != 16'hFFFF) begin
            st_dma_drop_cnt <= st_dma_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_glb_strm_st_dma.sv
// Directed bench for glb_strm_st_dma: NORMAL/REPEAT/AUTO_INCR runs, abort, drops and reset.
module tb_glb_strm_st_dma;
    import glb_strm_st_dma_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] mode = DMA_OFF;
    dma_st_header_t [3:0] hdr = '0;
    logic start = 1'b0;
    logic busy, done;
`ifdef GLB_ST_DMA_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif
    int checks = 0;
    int errors = 0;

    glb_strm_st_dma_if strm ();

    glb_strm_st_dma dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cfg_st_dma_mode    (mode),
        .cfg_st_dma_header  (hdr),
        .st_dma_start_pulse (start),
        .strm               (strm),
        .st_dma_busy        (busy),
`ifdef GLB_ST_DMA_DROP_CNT_EN
        .st_dma_drop_cnt    (drop_cnt),
`endif
        .st_dma_done_pulse  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [21:0] a, input logic [7:0] s,
                          input logic [63:0] d);
        chk({tag, "_en"}, 128'(strm.wr_packet.wr_en), 128'(1'b1));
        chk({tag, "_addr"}, 128'(strm.wr_packet.wr_addr), 128'(a));
        chk({tag, "_strb"}, 128'(strm.wr_packet.wr_strb), 128'(s));
        chk({tag, "_data"}, 128'(strm.wr_packet.wr_data), 128'(d));
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic put_word(input logic [15:0] d);
        strm.stream_data_valid_f2g = 1'b1;
        strm.stream_data_f2g = d;
        tick();
        strm.stream_data_valid_f2g = 1'b0;
    endtask

    initial begin
        strm.stream_data_f2g = '0;
        strm.stream_data_valid_f2g = 1'b0;
        tick();
        tick();
        chk("rst_wr_packet", 128'(strm.wr_packet), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        reset_n = 1'b1;
        tick();

        // NORMAL, aligned, 8 words -> two full bank writes
        mode = NORMAL;
        hdr = '0;
        hdr[0] = '{valid: 1'b1, start_addr: 22'h100, num_words: 16'd8};
        start_run();
        chk("n_busy", 128'(busy), 128'(1));
        tick();
        for (int i = 1; i <= 8; i++) begin
            put_word(16'(i));
            if (i == 4) chk_wr("n_wr0", 22'h100, 8'hFF, 64'h0004_0003_0002_0001);
            if (i == 5) chk("n_wr_en_one_cycle", 128'(strm.wr_packet.wr_en), 128'(0));
        end
        chk_wr("n_wr1", 22'h108, 8'hFF, 64'h0008_0007_0006_0005);
        tick();
        chk("n_done", 128'(done), 128'(1));
        chk("n_idle", 128'(busy), 128'(0));
        tick();
        chk("n_done_one_cycle", 128'(done), 128'(0));

        // unaligned start, 3 words -> one partial write
        hdr[0] = '{valid: 1'b1, start_addr: 22'h102, num_words: 16'd3};
        start_run();
        tick();
        put_word(16'h0011);
        put_word(16'h0022);
        put_word(16'h0033);
        chk_wr("u_wr", 22'h100, 8'hFC, 64'h0033_0022_0011_0000);
        tick();
        chk("u_done", 128'(done), 128'(1));

        // zero-length header -> done 3 cycles after start, no write
        hdr[0] = '{valid: 1'b1, start_addr: 22'h100, num_words: 16'd0};
        start_run();
        tick();
        chk("z_no_done_early", 128'(done), 128'(0));
        chk("z_no_wr", 128'(strm.wr_packet.wr_en), 128'(0));
        tick();
        chk("z_done", 128'(done), 128'(1));
        chk("z_idle", 128'(busy), 128'(0));

        // REPEAT, two passes then abort mid-bank-word
        mode = REPEAT;
        hdr[0] = '{valid: 1'b1, start_addr: 22'h0, num_words: 16'd4};
        start_run();
        for (int p = 0; p < 2; p++) begin
            tick();
            for (int i = 1; i <= 4; i++) put_word(16'(8'hA0 + 16 * p + i));
            chk_wr("r_wr", 22'h0, 8'hFF,
                   {16'(8'hA4 + 16 * p), 16'(8'hA3 + 16 * p), 16'(8'hA2 + 16 * p), 16'(8'hA1 + 16 * p)});
            tick();
            chk("r_done", 128'(done), 128'(1));
            chk("r_busy", 128'(busy), 128'(1));
        end
        tick();
        put_word(16'h00C1);
        put_word(16'h00C2);
        mode = DMA_OFF;
        strm.stream_data_valid_f2g = 1'b1;
        strm.stream_data_f2g = 16'h00C3;
        tick();
        strm.stream_data_valid_f2g = 1'b0;
        chk("r_abort_busy", 128'(busy), 128'(0));
        chk("r_abort_no_done", 128'(done), 128'(0));
        chk("r_abort_no_wr", 128'(strm.wr_packet.wr_en), 128'(0));
        tick();
        chk("r_abort_no_wr_late", 128'(strm.wr_packet.wr_en), 128'(0));

        // start is ignored while the DMA is off
        start_run();
        chk("off_start_ignored", 128'(busy), 128'(0));

        // AUTO_INCR, three headers stepping the address
        mode = AUTO_INCR;
        hdr[0] = '{valid: 1'b1, start_addr: 22'h40, num_words: 16'd4};
        start_run();
        for (int p = 0; p < 3; p++) begin
            tick();
            for (int i = 1; i <= 4; i++) put_word(16'(4 * p + i));
            chk_wr("a_wr", 22'(22'h40 + 8 * p), 8'hFF,
                   {16'(4 * p + 4), 16'(4 * p + 3), 16'(4 * p + 2), 16'(4 * p + 1)});
            if (p < 2) begin
                tick();
                chk("a_done", 128'(done), 128'(1));
            end
        end
        mode = DMA_OFF;
        tick();
        chk("a_off_busy", 128'(busy), 128'(0));
        chk("a_off_no_done", 128'(done), 128'(0));

        // valid words while idle are dropped
        mode = NORMAL;
        for (int i = 0; i < 5; i++) begin
            put_word(16'hDEAD);
            chk("drop_no_wr", 128'(strm.wr_packet.wr_en), 128'(0));
        end
`ifdef GLB_ST_DMA_DROP_CNT_EN
        chk("drop_cnt", 128'(drop_cnt), 128'(5));
`endif

        // reset in the middle of STREAM clears everything including the pack register
        hdr[0] = '{valid: 1'b1, start_addr: 22'h100, num_words: 16'd8};
        start_run();
        tick();
        put_word(16'h0E01);
        put_word(16'h0E02);
        put_word(16'h0E03);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr_packet", 128'(strm.wr_packet), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_done", 128'(done), 128'(0));
`ifdef GLB_ST_DMA_DROP_CNT_EN
        chk("mid_rst_drop_cnt", 128'(drop_cnt), 128'(0));
`endif
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_no_wr", 128'(strm.wr_packet.wr_en), 128'(0));
        hdr[0] = '{valid: 1'b1, start_addr: 22'h106, num_words: 16'd1};
        start_run();
        tick();
        put_word(16'h0055);
        chk_wr("post_rst_wr", 22'h100, 8'hC0, 64'h0055_0000_0000_0000);
        tick();
        chk("post_rst_done", 128'(done), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glb_strm_st_dma.md
# glb_strm_st_dma

Store-direction stream DMA of a GLB tile: the writer for the stream path. It consumes the 16-bit CGRA output stream (fabric-to-GLB), packs words into 64-bit bank words, and emits byte-strobed `wr_packet_t` writes toward the tile's bank switch. Transfers are driven by a small queue of `dma_st_header_t` headers under the shared `DMA_OFF/NORMAL/REPEAT/AUTO_INCR` mode encoding.

## Interface
- `BANK_DATA_WIDTH`, 64: bank word width.
- `CGRA_DATA_WIDTH`, 16: stream word width; must divide `BANK_DATA_WIDTH`; 4 lanes at defaults.
- `GLB_ADDR_WIDTH`, 22: byte address width.
- `MAX_NUM_WORDS_WIDTH`, 16: header word-count width.
- `QUEUE_DEPTH`, 4: number of header slots.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_st_dma_mode` in 2: DMA mode.
- `cfg_st_dma_header` in `QUEUE_DEPTH` × `dma_st_header_t`: header slots, sampled when a header is loaded.
- `st_dma_start_pulse` in 1: starts a run.
- `stream_data_f2g` in `CGRA_DATA_WIDTH`: stream word.
- `stream_data_valid_f2g` in 1: stream word valid. There is no ready signal; every valid word is consumed or dropped.
- `wr_packet` out `wr_packet_t`: registered bank write.
- `st_dma_busy` out 1: high outside `IDLE`.
- `st_dma_done_pulse` out 1: one-cycle pass-complete pulse.

## Operation
- FSM states: `IDLE`, `LOAD`, `STREAM`, `FLUSH`.
- `IDLE`:
  - On `st_dma_start_pulse` with mode != `DMA_OFF`, set slot index to 0 and go to `LOAD`.
  - Start is ignored in `DMA_OFF` and in any non-`IDLE` state.
- `LOAD`:
  - Latch slot `valid`, `start_addr` (bit0 forced to 0) and `num_words`.
  - If `valid`=0 or `num_words`=0, the header is complete with no write; apply end-of-header rules.
  - Otherwise go to `STREAM`.
- `STREAM`, per valid word:
  - Lane = `addr[2:1]`, where `addr = start_addr + 2*k` and `k` is the word index.
  - Write the word into that lane of the pack register and set the lane's 2 strobe bits.
  - Emit a write when lane = 3 or the word is the header's last word.
  - Write fields: `wr_addr` = `addr` with bits [2:0] cleared; `wr_strb` = accumulated strobe; `wr_data` = pack register. Then clear the strobe.
- An unaligned `start_addr` produces a leading partial word. A short count produces a trailing partial word.
- After the last word, go to `FLUSH` (one cycle), then apply end-of-header rules.
- End of header:
  - Next slot exists and is valid: go to `LOAD` for it.
  - `NORMAL`: at the first invalid slot or past the last slot, pulse done and go to `IDLE`.
  - `REPEAT`: at the end of the pass, pulse done and wrap to slot 0.
  - `AUTO_INCR`: reload the same slot's `num_words`, set `start_addr` = previous end address, and pulse done after every header.
- Mode changes to `DMA_OFF` while busy: abort in the same cycle, discard the partial pack register, no done pulse, go to `IDLE`.
- Stream valid outside `STREAM` (in `IDLE`, `LOAD` or `FLUSH`): the word is dropped.
- Address arithmetic is modulo 2^`GLB_ADDR_WIDTH` and wraps silently.

## Timing
- Reset values: `wr_packet` = 0, `st_dma_busy` = 0, `st_dma_done_pulse` = 0, FSM = `IDLE`, pack register = 0.
- `wr_packet.wr_en` rises 1 cycle after the valid word that completes a bank word. `wr_en` is high for exactly one cycle.
- Back-to-back full bank words sustain one write every 4 cycles.
- Start to first-accepted-word: start in cycle t, `LOAD` in t+1, `STREAM` from t+2.
- `st_dma_done_pulse` is asserted in the cycle after `FLUSH` of the completing header.
- Reset asserted mid-run: all state clears immediately; no write is emitted.

## Configuration
- `GLB_ST_DMA_DROP_CNT_EN`:
  - Defined: adds output `st_dma_drop_cnt` [15:0], which counts valid words dropped outside `STREAM`. It saturates at 0xFFFF and is cleared by reset and by `st_dma_start_pulse`.
  - Undefined: port absent and no counter logic.

## Structure
- Shared package additions:
  - `st_dma_state_t` enum (`IDLE/LOAD/STREAM/FLUSH`).
  - Constant `CGRA_WORDS_PER_BANK_WORD` = `BANK_DATA_WIDTH/CGRA_DATA_WIDTH`.
  - Reuse the existing mode constants and `wr_packet_t`/`dma_st_header_t`.
- Sub-module `glb_st_word_packer` contains the pack register, lane select, strobe accumulation and emit decision. The FSM, header sequencing and address counter stay in the top.

## Test plan
- `NORMAL`, slot0 {1, 0x100, 8}, 8 consecutive words 0x1..0x8 -> 2 writes:
  - First: addr 0x100, strb 0xFF, data 0x0004_0003_0002_0001.
  - Second: addr 0x108, data 0x0008_0007_0006_0005.
  - Then done pulse.
- Slot0 {1, 0x102, 3} -> single write: addr 0x100, strb 0xFC, lanes 1-3 filled.
- Slot0 {1, 0x100, 0}, slot1 invalid -> no write, done pulse 3 cycles after start.
- `REPEAT` with slot0 {1, 0x0, 4} -> writes at 0x0 each pass, one done pulse per pass. Switch mode to `DMA_OFF` after 2 words -> no further write, busy low the next cycle.
- `AUTO_INCR` with slot0 {1, 0x40, 4} -> writes at 0x40, 0x48, 0x50, ..., one done pulse each.
- Valid words during `IDLE` -> no write; with `GLB_ST_DMA_DROP_CNT_EN`, 5 such words give `st_dma_drop_cnt` = 5. Assert reset mid-`STREAM` -> all outputs 0.
